rbm_inference_controller: RTL

Sequencer for the two-layer stochastic RBM classifier datapath. It accepts an inference request and holds the datapath in reset, then releases it and discards its pipeline-fill outputs. It then accumulates a programmable number of output samples per class lane, resolves the winning class by sequential argmax, and returns the result over a valid/ready handshake. It sits between the host/test harness and the RBM datapath, replacing free-running accumulation with a bounded, restartable run.

---
 rtl/rbm_inference_controller.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/rbm_inference_controller.sv
// Bounded-run sequencer for the stochastic RBM classifier datapath: holds the datapath in
// reset, settles it, accumulates N samples per class lane, resolves argmax, hands back the result.
module rbm_inference_controller #(
   parameter int output_bitlength   = 12,
   parameter int out_dim            = 2,
   parameter int acc_bitlength      = 16,
   parameter int counter_bit_length = 10,
   parameter int settle_cycles      = 2,
   parameter int class_bitlength    = 4
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  start_valid_i,
   output logic                                  start_ready_o,
   input  logic [counter_bit_length-1:0]         iter_num_i,
   input  logic                                  abort_i,
   output logic                                  dp_reset_o,
   input  logic [out_dim*output_bitlength-1:0]   dp_output_i,
   output logic [out_dim*acc_bitlength-1:0]      cumulation_o,
   output logic [class_bitlength-1:0]            result_class_o,
   output logic                                  result_valid_o,
   input  logic                                  result_ready_i,
   output logic                                  busy_o
);

   // state    | meaning
   // S_IDLE   | waiting for a request; datapath held in reset
   // S_CLEAR  | one cycle: zero accumulators, class and counters
   // S_SETTLE | datapath released; pipeline-fill outputs discarded
   // S_ACCUM  | N cycles of saturating per-lane accumulation
   // S_ARGMAX | one lane per cycle, strictly-greater replaces the best
   // S_DONE   | result offered on valid/ready; outputs frozen

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SETTLE,
      S_ACCUM,
      S_ARGMAX,
      S_DONE
   } state_t;

   localparam int CW0 = (counter_bit_length > class_bitlength) ? counter_bit_length : class_bitlength;
   localparam int SB  = $clog2(settle_cycles + 1);
   localparam int CW  = (CW0 > SB) ? CW0 : SB;
   localparam int SW  = ((acc_bitlength > output_bitlength) ? acc_bitlength : output_bitlength) + 1;
   localparam logic [acc_bitlength-1:0]   ACC_MAX   = '1;
   localparam logic [class_bitlength-1:0] LANE_LAST = class_bitlength'(out_dim - 1);

   state_t                          state_q, state_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic [counter_bit_length-1:0]   n_q, n_d;
   logic [class_bitlength-1:0]      lane_q, lane_d;
   logic [class_bitlength-1:0]      class_q, class_d;
   logic [acc_bitlength-1:0]        best_q, best_d;
   logic [acc_bitlength-1:0]        acc_q [out_dim];
   logic [acc_bitlength-1:0]        acc_d [out_dim];
   logic [acc_bitlength-1:0]        sel_val;
   logic [SW-1:0]                   sum;
   logic                            dp_reset_q, dp_reset_d;
   logic                            result_valid_q, result_valid_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (abort_i && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (start_valid_i) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_SETTLE;
            S_SETTLE: if (cnt_q == '0) state_d = (n_q == '0) ? S_ARGMAX : S_ACCUM;
            S_ACCUM:  if (cnt_q == '0) state_d = S_ARGMAX;
            S_ARGMAX: if (lane_q == LANE_LAST) state_d = S_DONE;
            S_DONE:   if (result_ready_i) state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // Registered outputs are decoded from the next state so they line up with the state register.
   always_comb begin
      dp_reset_d     = !((state_d == S_SETTLE) || (state_d == S_ACCUM));
      result_valid_d = (state_d == S_DONE);
   end

   assign start_ready_o = (state_q == S_IDLE);
   assign busy_o        = (state_q != S_IDLE);

   always_comb begin
      sel_val = '0;
      for (int l = 0; l < out_dim; l++) begin
         if (lane_q == class_bitlength'(l)) sel_val = acc_q[l];
      end
   end

   always_comb begin
      cnt_d   = cnt_q;
      n_d     = n_q;
      lane_d  = lane_q;
      class_d = class_q;
      best_d  = best_q;
      sum     = '0;
      for (int l = 0; l < out_dim; l++) acc_d[l] = acc_q[l];

      if (abort_i && (state_q != S_IDLE)) begin
         cnt_d   = '0;
         lane_d  = '0;
         class_d = '0;
         best_d  = '0;
         for (int l = 0; l < out_dim; l++) acc_d[l] = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_valid_i) n_d = iter_num_i;
            end
            S_CLEAR: begin
               cnt_d   = CW'(settle_cycles - 1);
               lane_d  = '0;
               class_d = '0;
               best_d  = '0;
               for (int l = 0; l < out_dim; l++) acc_d[l] = '0;
            end
            S_SETTLE: begin
               if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
               else if (n_q != '0) cnt_d = CW'(n_q) - CW'(1);
               else cnt_d = '0;
            end
            S_ACCUM: begin
               if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
               for (int l = 0; l < out_dim; l++) begin
                  sum = SW'(acc_q[l]) + SW'(dp_output_i[l*output_bitlength +: output_bitlength]);
                  acc_d[l] = (sum > SW'(ACC_MAX)) ? ACC_MAX : sum[acc_bitlength-1:0];
               end
            end
            S_ARGMAX: begin
               // Lane 0 always wins against the zeroed best unless it is zero, where class 0 stands anyway.
               if (sel_val > best_q) begin
                  best_d  = sel_val;
                  class_d = lane_q;
               end
               if (lane_q != LANE_LAST) lane_d = lane_q + class_bitlength'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q          <= '0;
         n_q            <= '0;
         lane_q         <= '0;
         class_q        <= '0;
         best_q         <= '0;
         dp_reset_q     <= 1'b1;
         result_valid_q <= 1'b0;
         for (int l = 0; l < out_dim; l++) acc_q[l] <= '0;
      end else begin
         cnt_q          <= cnt_d;
         n_q            <= n_d;
         lane_q         <= lane_d;
         class_q        <= class_d;
         best_q         <= best_d;
         dp_reset_q     <= dp_reset_d;
         result_valid_q <= result_valid_d;
         for (int l = 0; l < out_dim; l++) acc_q[l] <= acc_d[l];
      end
   end

   for (genvar g = 0; g < out_dim; g++) begin : g_pack
      assign cumulation_o[g*acc_bitlength +: acc_bitlength] = acc_q[g];
   end

   assign dp_reset_o     = dp_reset_q;
   assign result_valid_o = result_valid_q;
   assign result_class_o = class_q;

endmodule
